// File: rtl/masked_gf256_mult_pipe.sv
// Boolean-masked GF(2^8) multiplier/squarer (AES field), two-stage pipeline with
// valid/ready handshakes: S1 registers all cross terms, S2 registers compressed shares.
module masked_gf256_mult_pipe #(
   parameter  int NSHARES = 2,
   localparam int NR      = NSHARES * (NSHARES - 1) / 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 sq_mode,
   input  logic [8*NSHARES-1:0] a_sh,
   input  logic [8*NSHARES-1:0] b_sh,
   input  logic [8*NR-1:0]      rnd,
   input  logic                 rnd_valid,
   output logic                 rnd_ack,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*NSHARES-1:0] y_sh
);

   localparam int NT = NSHARES * NSHARES;

   // Polynomial multiply to 15 bits, then fold the high bits back with 0x11B.
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ (15'(x) << i);
      end
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
      end
      return p[7:0];
   endfunction

   // Word index of the random byte shared by pair (i,j), i<j, in lexicographic order.
   function automatic int rnd_index(input int i, input int j);
      return i * (NSHARES - 1) - (i * (i - 1)) / 2 + (j - i - 1);
   endfunction

   logic             s1_valid;
   logic [7:0]       t_q    [NT];
   logic [7:0]       term_d [NT];
   logic [8*NSHARES-1:0] y_d;
   logic             s1_adv;
   logic             s2_adv;
   logic             accept;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign accept   = in_valid && in_ready && (sq_mode || rnd_valid);
   assign rnd_ack  = accept && !sq_mode;

   for (genvar i = 0; i < NSHARES; i++) begin : g_row
      for (genvar j = 0; j < NSHARES; j++) begin : g_col
         if (i == j) begin : g_diag
            assign term_d[i*NSHARES+j] =
               gf_mul(a_sh[8*i +: 8], sq_mode ? a_sh[8*i +: 8] : b_sh[8*i +: 8]);
         end else begin : g_cross
            // Both halves of a symmetric pair are masked by the same random byte,
            // so it cancels only when the two output shares are combined.
            localparam int K = rnd_index((i < j) ? i : j, (i < j) ? j : i);
            assign term_d[i*NSHARES+j] = sq_mode ? 8'h00 :
               (gf_mul(a_sh[8*i +: 8], b_sh[8*j +: 8]) ^ rnd[8*K +: 8]);
         end
      end
   end

   // Compression reads registered terms only, never live input shares.
   always_comb begin
      y_d = '0;
      for (int i = 0; i < NSHARES; i++) begin
         for (int j = 0; j < NSHARES; j++) begin
            y_d[8*i +: 8] = y_d[8*i +: 8] ^ t_q[i*NSHARES+j];
         end
      end
   end

   // NOTE: the term array is reset element by element so no share residue
   // survives a reset; this is a register bank, not a RAM, so that is cheap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         for (int k = 0; k < NT; k++) t_q[k] <= '0;
      end else if (s1_adv) begin
         s1_valid <= accept;
         for (int k = 0; k < NT; k++) t_q[k] <= accept ? term_d[k] : 8'h00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         y_sh      <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         y_sh      <= s1_valid ? y_d : '0;
      end
   end

endmodule

// File: doc/masked_gf256_mult_pipe.md
MASKED_GF256_MULT_PIPE -- requirements
Module: masked_gf256_mult_pipe

Interface
REQ-001 Parameter: NSHARES, default 2, number of Boolean shares per operand; legal range 2..4.
REQ-002 Parameter: NR (derived, not overridable), value NSHARES*(NSHARES-1)/2, number of 8-bit fresh-randomness words per multiplication.
REQ-003 Clocking: single clock; reset is asynchronous and active-high.
REQ-004 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: in_valid  input  1  operand shares are presented.
REQ-007 Port: in_ready  output  1  pipeline can take a new operation this cycle.
REQ-008 Port: sq_mode  input  1  1 = square a and ignore b; 0 = multiply a*b.
REQ-009 Port: a_sh  input  8*NSHARES  shares of a; share i is bits [8i+7:8i].
REQ-010 Port: b_sh  input  8*NSHARES  shares of b, same packing as a_sh.
REQ-011 Port: rnd  input  8*NR  fresh randomness; word k is bits [8k+7:8k].
REQ-012 Port: rnd_valid  input  1  rnd holds unused random data.
REQ-013 Port: rnd_ack  output  1  rnd was consumed this cycle.
REQ-014 Port: out_valid  output  1  y_sh holds a result.
REQ-015 Port: out_ready  input  1  downstream accepts y_sh.
REQ-016 Port: y_sh  output  8*NSHARES  shares of the result, same packing as a_sh.

Function
REQ-017 Field arithmetic: GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1 (0x11B).
REQ-018 Output correctness: the XOR of all y_sh shares equals (XOR a_sh)*(XOR b_sh), or (XOR a_sh)^2 when sq_mode=1.
REQ-019 Pipeline: two register stages, S1 (cross terms) and S2 (compressed output shares); y_sh and out_valid are driven directly from S2 registers.
REQ-020 Latency: 2 cycles from accept to out_valid=1 when out_ready is held at 1.
REQ-021 Throughput: one operation per cycle sustained.
REQ-022 Advance rules:
  - S2 advances when out_valid=0 or out_ready=1.
  - S1 advances when S1 is empty or S2 advances.
  - in_ready = S1 advances.
REQ-023 Accept condition: in_valid & in_ready & (sq_mode | rnd_valid).
REQ-024 rnd_ack = accept & !sq_mode; it is combinational, and rnd is never consumed in square mode.
REQ-025 No randomness: in_valid=1, sq_mode=0, rnd_valid=0 → no accept, no state change, rnd_ack=0.
REQ-026 Multiply mode, S1 terms: for every ordered pair (i,j), register t_ij.
  - t_ii = a_i*b_i.
  - For i<j, using randomness word r_ij (k enumerated in lexicographic (i,j) order): t_ij = a_i*b_j ^ r_ij and t_ji = a_j*b_i ^ r_ij.
REQ-027 Square mode, S1 terms: t_ii = a_i^2 and all other t_ij = 0; this is share-local, uses no randomness and has the same 2-cycle latency.
REQ-028 S2 compression: y_i = XOR over j of t_ij, computed only from registered S1 terms; no unregistered share recombination anywhere.
REQ-029 Ordering: results leave in accept order.
REQ-030 Stall behaviour: while out_valid=1 and out_ready=0, y_sh and out_valid hold stable.
REQ-031 Back-to-back mixing of sq_mode and multiply operations is legal, and each result uses its own mode.
REQ-032 Bubbles: when a stage advances with no valid data, its data registers load 0, not stale shares.

Reset
REQ-033 While rst=1: out_valid=0, y_sh=0, S1 valid=0 and all S1 term registers=0, immediately and independent of clk.
REQ-034 Reset mid-operation discards all in-flight operations; no partial result is emitted after reset releases.
REQ-035 First cycle after reset release: in_ready=1.

Verification
REQ-036 NSHARES=2, a_sh={0x41,0x12} (a=0x53), b_sh={0xC5,0x0F} (b=0xCA), rnd=0x5A, rnd_valid=1, out_ready=1 → rnd_ack=1 in the accept cycle; 2 cycles later out_valid=1 and y0^y1=0x01.
REQ-037 sq_mode=1, a=0x80 (any share split), rnd_valid=0 → accepted with rnd_ack=0; XOR of shares of y_sh is 0x9A; a=0x02 gives 0x04.
REQ-038 in_valid=1, sq_mode=0, rnd_valid=0 for 5 cycles, then rnd_valid=1 → no accept and no out_valid for those 5 cycles; a single result appears 2 cycles after rnd_valid rises.
REQ-039 Stream of 4 multiplies with out_ready=0 from cycle 2 to 6 → in_ready=0 once S1 and S2 are full; y_sh stable during the stall; all 4 results are correct and in order after out_ready=1.
REQ-040 rst asserted 1 cycle after an accept → out_valid stays 0 through and after reset; in_ready=1 after release.
REQ-041 NSHARES=3 and NSHARES=4, 1000 random operands and random rnd, mixed sq_mode → the XOR of output shares matches the reference GF(2^8) product or square for every operation.
